step_pulse_gen: RTL and testbench

- Generates the active-low quarter-step timing signal `quarter` that feeds the downstream negative-edge detector in the stepper controller.
- On a start command it emits a programmed number of low pulses with programmable period and low width, then signals completion.
- Sits between the motion sequencer, which issues start/steps/period, and the edge-detect/phase-stepping logic.

---
 rtl/step_pulse_gen.sv | 129 ++++++++++++
 tb/tb_step_pulse_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// Active-low quarter-step pulse generator: emits a programmed number of low pulses
// with a programmable period and low width, then a one-cycle done pulse.
module step_pulse_gen #(
  parameter int CNT_W  = 24,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  low_width,
  input  logic              abort,
  output logic              quarter,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] step_count
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  period_r, lw_r;
  logic [CNT_W-1:0]  phase_cnt, phase_nx;
  logic [STEP_W-1:0] remaining, remaining_nx;
  logic [STEP_W-1:0] step_nx;
  logic              aborted_nx;
  logic              load;
  logic [CNT_W-1:0]  period_eff, lw_eff;

  // Clamp so both phases are at least one cycle; the counters can never wrap.
  always_comb begin
    period_eff = (period < CNT_W'(2)) ? CNT_W'(2) : period;
    if (low_width == '0)
      lw_eff = CNT_W'(1);
    else if (low_width >= period_eff)
      lw_eff = period_eff - CNT_W'(1);
    else
      lw_eff = low_width;
  end

  always_comb begin
    state_nx     = state;
    phase_nx     = phase_cnt;
    remaining_nx = remaining;
    step_nx      = step_count;
    aborted_nx   = aborted;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          aborted_nx = 1'b0;
          if (steps != '0) begin
            state_nx     = LOW;
            phase_nx     = lw_eff;
            remaining_nx = steps - STEP_W'(1);
            step_nx      = STEP_W'(1);
            load         = 1'b1;
          end else begin
            state_nx = FINISH;
            step_nx  = '0;
          end
        end
      end
      LOW: begin
        if (abort) begin
          state_nx   = FINISH;
          aborted_nx = 1'b1;
        end else if (phase_cnt == CNT_W'(1)) begin
          state_nx = HIGH;
          phase_nx = period_r - lw_r;
        end else begin
          phase_nx = phase_cnt - CNT_W'(1);
        end
      end
      HIGH: begin
        if (abort) begin
          state_nx   = FINISH;
          aborted_nx = 1'b1;
        end else if (phase_cnt == CNT_W'(1)) begin
          if (remaining == '0) begin
            state_nx = FINISH;
          end else begin
            // Next falling edge: count the new pulse, saturating at all-ones.
            state_nx     = LOW;
            phase_nx     = lw_r;
            remaining_nx = remaining - STEP_W'(1);
            step_nx      = (&step_count) ? step_count : step_count + STEP_W'(1);
          end
        end else begin
          phase_nx = phase_cnt - CNT_W'(1);
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      remaining  <= '0;
      period_r   <= '0;
      lw_r       <= '0;
      step_count <= '0;
      aborted    <= 1'b0;
      quarter    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      phase_cnt  <= phase_nx;
      remaining  <= remaining_nx;
      step_count <= step_nx;
      aborted    <= aborted_nx;
      if (load) begin
        period_r <= period_eff;
        lw_r     <= lw_eff;
      end
      quarter <= (state_nx != LOW);
      busy    <= (state_nx == LOW) || (state_nx == HIGH);
      done    <= (state_nx == FINISH);
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: each run pushes its expected profile, and a
// monitor measures the quarter/busy waveform and checks it when done pulses.
module tb_step_pulse_gen;
  localparam int CNT_W  = 24;
  localparam int STEP_W = 16;

  logic              clk = 1'b0;
  logic              resetb = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [STEP_W-1:0] steps = '0;
  logic [CNT_W-1:0]  period = '0;
  logic [CNT_W-1:0]  low_width = '0;
  logic              quarter, busy, done, aborted;
  logic [STEP_W-1:0] step_count;

  step_pulse_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk(clk), .resetb(resetb), .start(start), .steps(steps), .period(period),
    .low_width(low_width), .abort(abort), .quarter(quarter), .busy(busy),
    .done(done), .aborted(aborted), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   stamp;
    int   done_cyc;
    int   falls;
    int   lows;
    int   busys;
    int   last_fall;
    logic ab;
    int   sc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_seen = 0;
  int   runs_issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives start so it is sampled on the next rising edge (cycle 0 of the run),
  // records that edge as the run's time origin and returns in cycle 1.
  task automatic applyStimulus(input int st, input int pd, input int lw, input int dcyc,
                               input int nf, input int nl, input int nb, input int lf,
                               input logic ab, input int sc);
    exp_t e;
    @(negedge clk);
    steps     = STEP_W'(st);
    period    = CNT_W'(pd);
    low_width = CNT_W'(lw);
    start     = 1'b1;
    @(posedge clk);
    #1;
    e.stamp = cyc; e.done_cyc = dcyc; e.falls = nf; e.lows = nl; e.busys = nb;
    e.last_fall = lf; e.ab = ab; e.sc = sc;
    sb.push_back(e);
    runs_issued++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (done_seen < runs_issued && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (done_seen < runs_issued) begin
      checkOutput("done_timeout", done_seen, runs_issued);
      runs_issued = done_seen;
    end
  endtask

  // Monitor: measures each run and compares against the scoreboard on done.
  initial begin
    int   falls = 0, lows = 0, busys = 0, last_fall = 0;
    logic prev_q = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetb) begin
        sb.delete();
        falls = 0; lows = 0; busys = 0; last_fall = 0; prev_q = 1'b1;
      end else begin
        if (prev_q && !quarter) begin
          if (sb.size() == 0) begin
            checkOutput("stray_fall", 1, 0);
          end else begin
            falls++;
            last_fall = cyc - sb[0].stamp + 1;
            checkOutput("step_count_at_fall", step_count, falls);
          end
        end
        prev_q = quarter;
        if (!quarter) lows++;
        if (busy) busys++;
        if (done) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("done_cycle", cyc - e.stamp + 1, e.done_cyc);
            checkOutput("falling_edges", falls, e.falls);
            checkOutput("low_cycles", lows, e.lows);
            checkOutput("busy_cycles", busys, e.busys);
            checkOutput("last_fall_cycle", last_fall, e.last_fall);
            checkOutput("aborted", aborted, e.ab);
            checkOutput("final_step_count", step_count, e.sc);
            checkOutput("idle_at_done", {quarter, busy}, 2'b10);
          end
          falls = 0; lows = 0; busys = 0; last_fall = 0;
          done_seen++;
        end
      end
    end
  end

  initial begin
    #2 resetb = 1'b0;
    #1;
    checkOutput("reset_outputs", {quarter, busy, done, aborted, step_count}, {1'b1, 19'd0});
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_outputs", {quarter, busy, done, aborted, step_count}, {1'b1, 19'd0});
    end

    // Normal run: 3 steps of 10 cycles, low for 4.
    applyStimulus(3, 10, 4, 31, 3, 12, 30, 21, 1'b0, 3);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("hold_step_count", step_count, 3);
    checkOutput("hold_idle", {quarter, busy, done}, 3'b100);

    // Clamping: period 1 -> 2 with 1-cycle low; low_width above period -> period-1.
    applyStimulus(2, 1, 0, 5, 2, 2, 4, 3, 1'b0, 2);
    waitDone();
    applyStimulus(2, 5, 9, 11, 2, 8, 10, 6, 1'b0, 2);
    waitDone();

    // Zero steps: immediate done, never busy or low.
    applyStimulus(0, 10, 4, 1, 0, 0, 0, 0, 1'b0, 0);
    waitDone();

    // Abort run with an ignored restart in cycle 5 and abort in cycle 12.
    applyStimulus(100, 8, 2, 13, 2, 4, 12, 9, 1'b1, 2);
    repeat (4) @(negedge clk);
    steps = 16'd1; period = 24'd3; low_width = 24'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    waitDone();
    repeat (20) @(negedge clk);
    checkOutput("abort_hold_count", step_count, 2);
    checkOutput("abort_hold_flag", aborted, 1);

    // aborted clears on the next accepted start.
    applyStimulus(0, 4, 1, 1, 0, 0, 0, 0, 1'b0, 0);
    waitDone();

    // Reset mid-run while quarter is low: no done pulse, then a clean new run.
    applyStimulus(10, 6, 3, 0, 0, 0, 0, 0, 1'b0, 0);
    repeat (8) @(negedge clk);
    checkOutput("low_before_reset", quarter, 0);
    #2 resetb = 1'b0;
    #1;
    checkOutput("reset_mid_run", {quarter, busy, done}, 3'b100);
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    runs_issued = done_seen;
    repeat (5) @(negedge clk);
    applyStimulus(1, 6, 3, 7, 1, 3, 6, 1, 1'b0, 1);
    waitDone();
    repeat (5) @(negedge clk);
    checkOutput("pending_runs", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
